present_decrypt_core: RTL and testbench
=======================================

// Module: present_decrypt_core
// PURPOSE
//  Iterative PRESENT-80 decryption engine; inverse of the encrypt datapath built from PLayer/S-box.
//  Accepts 64-bit ciphertext + original 80-bit key, derives the final round key on-chip, then runs
//  inverse rounds (inverse pLayer, inverse S-box, key XOR), one round per clock.
//  Sits beside the encrypt core behind the same valid/ready block interface.
// PARAMETERS
//  ROUNDS   31  number of cipher rounds (31 = standard PRESENT; smaller values for reduced-round debug)
// PORTS
//  clk         in   1   system clock, all flops rising-edge
//  reset       in   1   synchronous, active-low reset
//  in_valid    in   1   ciphertext/key request valid
//  in_ready    out  1   core can accept a request
//  ciphertext  in   64  ciphertext block, sampled on accept
//  key         in   80  original (encryption) key, sampled on accept
//  out_valid   out  1   plaintext valid
//  out_ready   in   1   consumer accepts plaintext
//  plaintext   out  64  recovered plaintext, stable while out_valid=1
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE, in_ready=1, out_valid=0, plaintext=0, round ctr=0,
//    cache invalidated. Reset mid-operation aborts; no partial result is ever presented.
//  - FSM: IDLE -> EXPAND -> WHITEN -> ROUND -> DONE -> IDLE.
//    IDLE:   in_ready=1; accept on in_valid&in_ready: load state<=ciphertext, keyreg<=key, ctr<=1.
//    EXPAND: ROUNDS cycles of forward schedule: keyreg<=rotl61, S(top nibble), bits[19:15]^=ctr; ctr++.
//            Leaves keyreg = K_(ROUNDS+1), ctr = ROUNDS.
//    WHITEN: state <= state ^ keyreg[79:16] (1 cycle).
//    ROUND:  per cycle: state <= invS(invP(state)) ^ K_ctr, with keyreg first stepped back:
//            bits[19:15]^=ctr, invS(top nibble), rotr61; ctr--. Exits after ctr==1 processed.
//    DONE:   out_valid=1, plaintext=state; hold until out_ready; on out_valid&out_ready -> IDLE.
//  - Latency (no cache hit): out_valid rises 2*ROUNDS+1 cycles after accepting edge (63 for ROUNDS=31).
//  - in_ready low in every state except IDLE; no new request overlaps; in_valid ignored elsewhere.
//  - out_ready asserted before DONE has no effect; out_ready low in DONE: hold output indefinitely.
//  - Round counter 5 bits; counter XOR uses ctr[4:0] only; ctr never wraps (1..ROUNDS).
//  - in_ready returns 1 the cycle after the DONE handshake (no same-cycle turnaround).
// CONFIGURATION
//  PRESENT_KEY_CACHE_EN defined: core stores last original key and its final round key (valid bit).
//    On accept, if cache valid and key==cached key, IDLE -> WHITEN directly with keyreg<=cached K_final;
//    latency ROUNDS+1 (32). Cache written at end of EXPAND; cleared by reset only.
//  Not defined: no cache storage; EXPAND always runs; latency always 2*ROUNDS+1.
// STRUCTURE
//  present_pkg: SBOX / INV_SBOX 4-bit lookup tables, BLOCK_W=64, KEY_W=80, CTR_W=5, FSM state enum.
//  Sub-module present_player_inv: combinational inverse bit permutation (bit P(i) -> bit i,
//    P(i)=16*i mod 63, P(63)=63); instantiated once in the ROUND datapath.
//  Key forward/backward step functions live in the core; share SBOX tables from package.
// TESTING
//  - ct=5579C1387B228445, key=0 -> plaintext=0000000000000000, out_valid 63 cycles after accept.
//  - ct=E72C46C0F5945049, key=FFFF_FFFFFFFFFFFFFFFF -> plaintext=0000000000000000.
//  - ct=A112FFC72F68417B, key=0 -> FFFFFFFFFFFFFFFF; then ct=3333DCD3213210D2, key=all-ones
//    -> FFFFFFFFFFFFFFFF; back-to-back with out_ready=1: in_ready=1 one cycle after each handshake.
//  - out_ready held 0 for 10 cycles in DONE -> plaintext/out_valid stable; in_valid pulses ignored.
//  - reset=0 for one cycle at round 15 -> out_valid=0, in_ready=1 next cycle; fresh request
//    decrypts correctly with full 63-cycle latency (cache invalidated).
//  - PRESENT_KEY_CACHE_EN: two requests same key -> second latency 32; changed key -> 63;
//    plaintexts match the non-cached build bit-for-bit.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, 4-bit S-box tables and the decrypt FSM encoding.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int CTR_W   = 5;

  // Nibble n of each table holds the substitution for input value n.
  localparam logic [63:0] SBOX_TBL     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX_TBL = 64'hA970364BD21C8FE5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_WHITEN,
    ST_ROUND,
    ST_DONE
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    return INV_SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/present_player_inv.sv
// Inverse PRESENT bit permutation: the forward layer moves bit i to P(i)=16*i mod 63 (bit 63 fixed).
module present_player_inv
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] data_i,
  output logic [BLOCK_W-1:0] data_o
);

  for (genvar i = 0; i < BLOCK_W - 1; i++) begin : g_bit
    assign data_o[i] = data_i[(16 * i) % 63];
  end

  assign data_o[BLOCK_W-1] = data_i[BLOCK_W-1];

endmodule

// File: rtl/present_decrypt_core.sv
// Iterative PRESENT-80 decryption, one inverse round per clock behind a valid/ready interface.
// Optional final-round-key cache enabled by defining PRESENT_KEY_CACHE_EN.
module present_decrypt_core
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [KEY_W-1:0]   key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] plaintext
);

  localparam logic [CTR_W-1:0] LAST_RND = CTR_W'(ROUNDS);

  function automatic logic [KEY_W-1:0] key_fwd(input logic [KEY_W-1:0] k,
                                               input logic [CTR_W-1:0] rc);
    logic [KEY_W-1:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = sbox(r[79:76]);
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  // Exact inverse of key_fwd: undo the counter XOR, then the S-box, then the rotation.
  function automatic logic [KEY_W-1:0] key_bwd(input logic [KEY_W-1:0] k,
                                               input logic [CTR_W-1:0] rc);
    logic [KEY_W-1:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = inv_sbox(r[79:76]);
    return {r[60:0], r[79:61]};
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < BLOCK_W / 4; n++) begin
      r[4*n +: 4] = inv_sbox(s[4*n +: 4]);
    end
    return r;
  endfunction

  state_e             fsm_q, fsm_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [KEY_W-1:0]   key_q, key_d;

  logic [KEY_W-1:0]   key_next;
  logic [KEY_W-1:0]   key_prev;
  logic [BLOCK_W-1:0] blk_pinv;

  assign key_next = key_fwd(key_q, ctr_q);
  assign key_prev = key_bwd(key_q, ctr_q);

  present_player_inv u_player_inv (
    .data_i (blk_q),
    .data_o (blk_pinv)
  );

`ifdef PRESENT_KEY_CACHE_EN
  logic               cache_vld_q;
  logic [KEY_W-1:0]   cache_key_q;
  logic [KEY_W-1:0]   cache_kfin_q;
  logic [KEY_W-1:0]   orig_key_q;
  logic               cache_wr;
  logic               cache_hit;

  assign cache_hit = cache_vld_q && (key == cache_key_q);
`endif

  always_comb begin
    fsm_d     = fsm_q;
    ctr_d     = ctr_q;
    blk_d     = blk_q;
    key_d     = key_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    plaintext = '0;
`ifdef PRESENT_KEY_CACHE_EN
    cache_wr  = 1'b0;
`endif
    unique case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          blk_d = ciphertext;
          key_d = key;
          ctr_d = CTR_W'(1);
          fsm_d = ST_EXPAND;
`ifdef PRESENT_KEY_CACHE_EN
          if (cache_hit) begin
            key_d = cache_kfin_q;
            ctr_d = LAST_RND;
            fsm_d = ST_WHITEN;
          end
`endif
        end
      end
      ST_EXPAND: begin
        key_d = key_next;
        if (ctr_q == LAST_RND) begin
          fsm_d = ST_WHITEN;
`ifdef PRESENT_KEY_CACHE_EN
          cache_wr = 1'b1;
`endif
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end
      ST_WHITEN: begin
        blk_d = blk_q ^ key_q[79:16];
        fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        // key_prev is K_ctr, the key that was XORed before this round's S/P layers.
        key_d = key_prev;
        blk_d = inv_sbox_layer(blk_pinv) ^ key_prev[79:16];
        if (ctr_q == CTR_W'(1)) begin
          fsm_d = ST_DONE;
        end else begin
          ctr_d = ctr_q - 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        plaintext = blk_q;
        if (out_ready) begin
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q <= ST_IDLE;
      ctr_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      ctr_q <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    blk_q <= blk_d;
    key_q <= key_d;
  end

`ifdef PRESENT_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cache_vld_q <= 1'b0;
    end else if (cache_wr) begin
      cache_vld_q <= 1'b1;
    end
  end

  // keyreg is overwritten during expansion, so the original key is kept for the cache tag.
  always_ff @(posedge clk) begin
    if (fsm_q == ST_IDLE && in_valid) begin
      orig_key_q <= key;
    end
    if (cache_wr) begin
      cache_key_q  <= orig_key_q;
      cache_kfin_q <= key_next;
    end
  end
`endif

endmodule

// File: tb/tb_present_decrypt_core.sv
// Scoreboard bench: a forward PRESENT-80 encryption model makes ciphertexts; a monitor checks results.
module tb_present_decrypt_core;

  localparam int R = 31;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] ciphertext = '0;
  logic [79:0] key = '0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;

  logic        rand_ready = 1'b0;
  logic        rnd_bit = 1'b1;
  logic        out_ready_force = 1'b1;

  assign out_ready = rand_ready ? rnd_bit : out_ready_force;

  present_decrypt_core #(.ROUNDS(R)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pt;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic        mc_vld = 1'b0;
  logic [79:0] mc_key = '0;

  logic [3:0] sb_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Textbook PRESENT-80 encryption: addRoundKey, sBoxLayer, pLayer, then key update.
  function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kr;
    s  = pt;
    kr = k;
    for (int r = 1; r <= R; r++) begin
      s = s ^ kr[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sb_tab[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      kr = {kr[18:0], kr[79:19]};
      kr[79:76] = sb_tab[kr[79:76]];
      kr[19:15] = kr[19:15] ^ 5'(r);
    end
    return s ^ kr[79:16];
  endfunction

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic send(input logic [63:0] ct, input logic [79:0] k, input logic [63:0] pt);
    exp_t e;
    int   n;
    logic hit;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_wait");
      return;
    end
    in_valid   = 1'b1;
    ciphertext = ct;
    key        = k;
    hit        = 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
    hit        = mc_vld && (mc_key == k);
`endif
    mc_vld     = 1'b1;
    mc_key     = k;
    e.pt       = pt;
    e.acc      = cyc + 1;
    e.lat      = hit ? (R + 1) : (2 * R + 1);
    sb.push_back(e);
    @(negedge clk);
    in_valid   = 1'b0;
    ciphertext = rand64();
    key        = rand80();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain");
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("wait_out_valid");
  endtask

  initial begin
    forever begin
      @(negedge clk);
      rnd_bit = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: samples just after the falling edge, when the inputs for the next rising edge are settled.
  initial begin
    logic ov_prev;
    logic hs_prev;
    exp_t e;
    ov_prev = 1'b0;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        ov_prev = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (hs_prev) begin
          chk("in_ready_after_handshake", 64'(in_ready), 64'(1));
          chk("out_valid_after_handshake", 64'(out_valid), 64'(0));
        end
        hs_prev = 1'b0;
        if (out_valid) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = sb[0];
            if (!ov_prev) begin
              chk("plaintext", plaintext, e.pt);
              chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end else begin
              chk("held_plaintext", plaintext, e.pt);
            end
            chk("in_ready_in_done", 64'(in_ready), 64'(0));
            if (out_ready) begin
              void'(sb.pop_front());
              hs_prev = 1'b1;
            end
          end
        end
        ov_prev = out_valid && !out_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pt;
    logic [63:0] pt2;
    logic [79:0] k;
    logic [79:0] pool [4];

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_plaintext", plaintext, 64'h0);
    reset = 1'b1;

    send(64'h5579C1387B228445, 80'h0, 64'h0);
    send(64'hE72C46C0F5945049, {80{1'b1}}, 64'h0);
    send(64'hA112FFC72F68417B, 80'h0, {64{1'b1}});
    send(64'h3333DCD3213210D2, {80{1'b1}}, {64{1'b1}});
    drain();

    // Same key twice, then a different key.
    k  = rand80();
    pt = rand64();
    send(present_enc(pt, k), k, pt);
    pt = rand64();
    send(present_enc(pt, k), k, pt);
    k  = rand80();
    pt = rand64();
    send(present_enc(pt, k), k, pt);
    drain();

    // Consumer stalls in DONE while stray requests are offered.
    out_ready_force = 1'b0;
    k  = rand80();
    pt = rand64();
    send(present_enc(pt, k), k, pt);
    wait_valid();
    repeat (10) begin
      in_valid   = $urandom_range(0, 1) != 0;
      ciphertext = rand64();
      key        = rand80();
      @(negedge clk);
    end
    in_valid        = 1'b0;
    out_ready_force = 1'b1;
    drain();

    // Abort mid-round with a one-cycle reset, then rerun with the same key.
    k  = rand80();
    pt = rand64();
    send(present_enc(pt, k), k, pt);
    repeat (R + 15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    mc_vld = 1'b0;
    pt2 = rand64();
    send(present_enc(pt2, k), k, pt2);
    drain();

    // Random traffic from a small key pool with a randomly stalling consumer.
    for (int i = 0; i < 4; i++) pool[i] = rand80();
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      k  = pool[$urandom_range(0, 3)];
      pt = rand64();
      send(present_enc(pt, k), k, pt);
    end
    drain();
    rand_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
